// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;
endpackage

// File: rtl/fetch_target_sel.sv
// Redirect target mux: picks JALR or branch target, word-aligns it, flags bit-1 misalignment.
module fetch_target_sel #(
  parameter int XLEN = 32
) (
  input  logic            jalr_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);
  logic [XLEN-1:0] raw;

  always_comb begin
    raw        = jalr_i ? {jalr_target_i[XLEN-1:1], 1'b0} : branch_target_i;
    target_o   = {raw[XLEN-1:2], 2'b00};
    misalign_o = raw[1];
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, issues one outstanding imem request, drives the IF/ID register.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            mpc_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
  output logic            flush_o,
  output logic            misalign_o
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, rpc_q, rpc_d, addr_q, addr_d, ifpc_q, ifpc_d;
  logic [31:0]     instr_q, instr_d;
  logic            req_q, req_d, vld_q, vld_d, mis_q, mis_d;
  logic [XLEN-1:0] tgt, pc_inc;
  logic            tgt_mis, redirect;

  fetch_target_sel #(.XLEN(XLEN)) u_tsel (
    .jalr_i          (jalr_i),
    .branch_target_i (branch_target_i),
    .jalr_target_i   (jalr_target_i),
    .target_o        (tgt),
    .misalign_o      (tgt_mis)
  );

  assign redirect = mpc_i | jalr_i;
  assign pc_inc   = pc_q + XLEN'(PC_INC);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    vld_d   = vld_q;
    ifpc_d  = ifpc_q;
    instr_d = instr_q;
    mis_d   = redirect & tgt_mis;

    if (redirect) begin
      vld_d = 1'b0;
      // A pending request must still drain its ack; only then may the new target go out.
      if (state_q == REQ || state_q == KILL) begin
        if (imem_ack_i) begin
          state_d = REQ;
          pc_d    = tgt;
          addr_d  = tgt;
          req_d   = 1'b1;
        end else begin
          state_d = KILL;
          rpc_d   = tgt;
        end
      end else begin
        state_d = REQ;
        pc_d    = tgt;
        addr_d  = tgt;
        req_d   = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
        REQ: begin
          if (imem_ack_i) begin
            vld_d   = 1'b1;
            ifpc_d  = pc_q;
            instr_d = imem_rdata_i;
            pc_d    = pc_inc;
            if (stall_i) begin
              state_d = HOLD;
              req_d   = 1'b0;
            end else begin
              addr_d  = pc_inc;
            end
          end else if (!stall_i) begin
            vld_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
            vld_d   = 1'b0;
          end
        end
        KILL: begin
          if (imem_ack_i) begin
            state_d = REQ;
            pc_d    = rpc_q;
            addr_d  = rpc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      rpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      ifpc_q  <= '0;
      instr_q <= NOP_INSTR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      ifpc_q  <= ifpc_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign if_valid_o  = vld_q;
  assign if_pc_o     = ifpc_q;
  assign if_instr_o  = instr_q;
  assign misalign_o  = mis_q;
  assign flush_o     = redirect;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed vector bench for fetch_pc_unit: one table of per-cycle inputs/expectations plus a reset sequence.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n, stall_i, mpc_i, jalr_i, imem_ack_i;
  logic [31:0] branch_target_i, jalr_target_i, imem_rdata_i;
  logic        imem_req_o, if_valid_o, flush_o, misalign_o;
  logic [31:0] imem_addr_o, if_pc_o, if_instr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .mpc_i           (mpc_i),
    .jalr_i          (jalr_i),
    .branch_target_i (branch_target_i),
    .jalr_target_i   (jalr_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_instr_o      (if_instr_o),
    .flush_o         (flush_o),
    .misalign_o      (misalign_o)
  );

  typedef struct {
    logic        stall, mpc, jalr;
    logic [31:0] btgt, jtgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_flush, e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc, e_instr;
    logic        e_mis;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic vec_t v(logic stall, logic mpc, logic jalr, logic [31:0] btgt, logic [31:0] jtgt,
                             logic ack, logic [31:0] rdata, logic e_flush, logic e_req,
                             logic [31:0] e_addr, logic e_vld, logic [31:0] e_pc,
                             logic [31:0] e_instr, logic e_mis);
    vec_t r;
    r.stall = stall; r.mpc = mpc; r.jalr = jalr; r.btgt = btgt; r.jtgt = jtgt;
    r.ack = ack; r.rdata = rdata; r.e_flush = e_flush; r.e_req = e_req; r.e_addr = e_addr;
    r.e_vld = e_vld; r.e_pc = e_pc; r.e_instr = e_instr; r.e_mis = e_mis;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req"},   {31'b0, imem_req_o}, 32'h0);
    check({tag, "_vld"},   {31'b0, if_valid_o}, 32'h0);
    check({tag, "_pc"},    if_pc_o, 32'h0);
    check({tag, "_instr"}, if_instr_o, 32'h0000_0013);
    check({tag, "_mis"},   {31'b0, misalign_o}, 32'h0);
  endtask

  initial begin
    //           stl mpc jlr btgt          jtgt          ack rdata         flush req addr          vld pc            instr         mis
    tbl[0]  = v(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 32'h0000_0000, 0, 32'h0,        32'h0,        0);
    tbl[1]  = v(0, 0, 0, 32'h0,        32'h0,        1, 32'h1000_0000, 0, 1, 32'h0000_0004, 1, 32'h0000_0000, 32'h1000_0000, 0);
    tbl[2]  = v(0, 0, 0, 32'h0,        32'h0,        1, 32'h1000_0004, 0, 1, 32'h0000_0008, 1, 32'h0000_0004, 32'h1000_0004, 0);
    tbl[3]  = v(1, 0, 0, 32'h0,        32'h0,        1, 32'h1000_0008, 0, 0, 32'h0,        1, 32'h0000_0008, 32'h1000_0008, 0);
    tbl[4]  = v(1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_0008, 32'h1000_0008, 0);
    tbl[5]  = v(1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_0008, 32'h1000_0008, 0);
    tbl[6]  = v(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 32'h0000_000C, 0, 32'h0,        32'h0,        0);
    tbl[7]  = v(0, 0, 0, 32'h0,        32'h0,        1, 32'h1000_000C, 0, 1, 32'h0000_0010, 1, 32'h0000_000C, 32'h1000_000C, 0);
    // Branch to 0x100 with the pending ack arriving two cycles later.
    tbl[8]  = v(0, 1, 0, 32'h100,      32'h0,        0, 32'h0,        1, 1, 32'h0000_0010, 0, 32'h0,        32'h0,        0);
    tbl[9]  = v(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 32'h0000_0010, 0, 32'h0,        32'h0,        0);
    tbl[10] = v(0, 0, 0, 32'h0,        32'h0,        1, 32'hDEAD_BEEF, 0, 1, 32'h0000_0100, 0, 32'h0,        32'h0,        0);
    tbl[11] = v(0, 0, 0, 32'h0,        32'h0,        1, 32'h1000_0100, 0, 1, 32'h0000_0104, 1, 32'h0000_0100, 32'h1000_0100, 0);
    // JALR to 0x203 with a simultaneous ack; branch target is a decoy.
    tbl[12] = v(0, 0, 1, 32'h555,      32'h203,      1, 32'hBAD0_0001, 1, 1, 32'h0000_0200, 0, 32'h0,        32'h0,        1);
    tbl[13] = v(0, 0, 0, 32'h0,        32'h0,        1, 32'h1000_0200, 0, 1, 32'h0000_0204, 1, 32'h0000_0200, 32'h1000_0200, 0);
    // Two redirects while killing; the later one wins.
    tbl[14] = v(0, 1, 0, 32'h40,       32'h0,        0, 32'h0,        1, 1, 32'h0000_0204, 0, 32'h0,        32'h0,        0);
    tbl[15] = v(0, 1, 0, 32'h80,       32'h0,        0, 32'h0,        1, 1, 32'h0000_0204, 0, 32'h0,        32'h0,        0);
    tbl[16] = v(0, 0, 0, 32'h0,        32'h0,        1, 32'hDEAD_0204, 0, 1, 32'h0000_0080, 0, 32'h0,        32'h0,        0);
    tbl[17] = v(0, 0, 0, 32'h0,        32'h0,        1, 32'h1000_0080, 0, 1, 32'h0000_0084, 1, 32'h0000_0080, 32'h1000_0080, 0);
    tbl[18] = v(0, 1, 0, 32'h306,      32'h0,        1, 32'hBAD0_0084, 1, 1, 32'h0000_0304, 0, 32'h0,        32'h0,        1);
    tbl[19] = v(0, 0, 0, 32'h0,        32'h0,        1, 32'h1000_0304, 0, 1, 32'h0000_0308, 1, 32'h0000_0304, 32'h1000_0304, 0);
    // Redirect beats stall; valid drops even though decode is stalled.
    tbl[20] = v(1, 1, 0, 32'h10,       32'h0,        0, 32'h0,        1, 1, 32'h0000_0308, 0, 32'h0,        32'h0,        0);
    tbl[21] = v(0, 0, 0, 32'h0,        32'h0,        1, 32'hDEAD_0308, 0, 1, 32'h0000_0010, 0, 32'h0,        32'h0,        0);
    // PC wrap at the top of the address space.
    tbl[22] = v(0, 1, 0, 32'hFFFF_FFFC, 32'h0,       1, 32'hBAD0_0010, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0,        0);
    tbl[23] = v(0, 0, 0, 32'h0,        32'h0,        1, 32'h1FFF_FFFC, 0, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h1FFF_FFFC, 0);
    tbl[24] = v(0, 0, 0, 32'h0,        32'h0,        1, 32'h1000_0000, 0, 1, 32'h0000_0004, 1, 32'h0000_0000, 32'h1000_0000, 0);

    rst_n = 1'b0; stall_i = 1'b0; mpc_i = 1'b0; jalr_i = 1'b0; imem_ack_i = 1'b0;
    branch_target_i = '0; jalr_target_i = '0; imem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #3 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      stall_i = tbl[i].stall; mpc_i = tbl[i].mpc; jalr_i = tbl[i].jalr;
      branch_target_i = tbl[i].btgt; jalr_target_i = tbl[i].jtgt;
      imem_ack_i = tbl[i].ack; imem_rdata_i = tbl[i].rdata;
      #1;
      check($sformatf("r%0d_flush", i), {31'b0, flush_o}, {31'b0, tbl[i].e_flush});
      @(posedge clk);
      #1;
      check($sformatf("r%0d_req", i), {31'b0, imem_req_o}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) check($sformatf("r%0d_addr", i), imem_addr_o, tbl[i].e_addr);
      check($sformatf("r%0d_vld", i), {31'b0, if_valid_o}, {31'b0, tbl[i].e_vld});
      if (tbl[i].e_vld) begin
        check($sformatf("r%0d_pc", i), if_pc_o, tbl[i].e_pc);
        check($sformatf("r%0d_instr", i), if_instr_o, tbl[i].e_instr);
      end
      check($sformatf("r%0d_mis", i), {31'b0, misalign_o}, {31'b0, tbl[i].e_mis});
    end

    // Request to 0x4 is pending; reset aborts it and a late ack must be ignored.
    stall_i = 1'b0; mpc_i = 1'b0; jalr_i = 1'b0; imem_ack_i = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    imem_ack_i = 1'b1; imem_rdata_i = 32'hCAFE_0004;
    @(posedge clk);
    #1 check_reset_outputs("rst_ack");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_late_req",  {31'b0, imem_req_o}, 32'h1);
    check("rst_late_addr", imem_addr_o, 32'h0);
    check("rst_late_vld",  {31'b0, if_valid_o}, 32'h0);
    imem_ack_i = 1'b1; imem_rdata_i = 32'h1000_0000;
    @(posedge clk);
    #1;
    check("rst_first_vld",   {31'b0, if_valid_o}, 32'h1);
    check("rst_first_pc",    if_pc_o, 32'h0);
    check("rst_first_instr", if_instr_o, 32'h1000_0000);
    check("rst_next_addr",   imem_addr_o, 32'h4);
    imem_ack_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
